// File: rtl/encode_reg_inst_writer_pkg.sv
// Shared R-type encoding constants and alu_control codes for the instruction writer.
// The macro definitions fall back to local values when processor_defines was not included first.
`ifndef ADD
`define ADD  5'd0
`endif
`ifndef SUB
`define SUB  5'd1
`endif
`ifndef SLL
`define SLL  5'd2
`endif
`ifndef SLT
`define SLT  5'd3
`endif
`ifndef SLTU
`define SLTU 5'd4
`endif
`ifndef XOR
`define XOR  5'd5
`endif
`ifndef SRL
`define SRL  5'd6
`endif
`ifndef SRA
`define SRA  5'd7
`endif
`ifndef OR
`define OR   5'd8
`endif
`ifndef AND
`define AND  5'd9
`endif

package encode_reg_inst_writer_pkg;
  localparam int INST_W = 32;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE  = 7'h00;
  localparam logic [6:0] FUNCT7_ALT   = 7'h20;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [4:0] ALU_ADD  = `ADD;
  localparam logic [4:0] ALU_SUB  = `SUB;
  localparam logic [4:0] ALU_SLL  = `SLL;
  localparam logic [4:0] ALU_SLT  = `SLT;
  localparam logic [4:0] ALU_SLTU = `SLTU;
  localparam logic [4:0] ALU_XOR  = `XOR;
  localparam logic [4:0] ALU_SRL  = `SRL;
  localparam logic [4:0] ALU_SRA  = `SRA;
  localparam logic [4:0] ALU_OR   = `OR;
  localparam logic [4:0] ALU_AND  = `AND;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  function automatic rtype_t encode_rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] funct3,
                                          input logic [6:0] funct7);
    rtype_t inst;
    inst.funct7 = funct7;
    inst.rs2    = rs2;
    inst.rs1    = rs1;
    inst.funct3 = funct3;
    inst.rd     = rd;
    inst.opcode = OPCODE_RTYPE;
    return inst;
  endfunction
endpackage

// File: rtl/encode_reg_inst_writer_inst_fifo.sv
// Synchronous FIFO holding encoded instruction words; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate occupancy counter.
module encode_reg_inst_writer_inst_fifo
  import encode_reg_inst_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INST_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign o_rdata   = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end
endmodule

// File: rtl/encode_reg_inst_writer.sv
// Re-encodes decoded R-type fields into RV32I words and streams them to instruction
// memory through a small FIFO, tracking write address, word count and illegal requests.
module encode_reg_inst_writer
  import encode_reg_inst_writer_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        alu_control,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              illegal_op,
  output logic [15:0]       inst_count
);
  logic              w_legal;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  rtype_t            w_inst;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_head;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic              r_illegal;
  logic [31:0]       r_last_wdata;

  always_comb begin
    w_legal  = 1'b1;
    w_funct3 = F3_ADD_SUB;
    w_funct7 = FUNCT7_BASE;
    case (alu_control)
      ALU_ADD:  w_funct3 = F3_ADD_SUB;
      ALU_SUB:  w_funct7 = FUNCT7_ALT;
      ALU_SLL:  w_funct3 = F3_SLL;
      ALU_SLT:  w_funct3 = F3_SLT;
      ALU_SLTU: w_funct3 = F3_SLTU;
      ALU_XOR:  w_funct3 = F3_XOR;
      ALU_SRL:  w_funct3 = F3_SRL_SRA;
      ALU_SRA: begin
        w_funct3 = F3_SRL_SRA;
        w_funct7 = FUNCT7_ALT;
      end
      ALU_OR:   w_funct3 = F3_OR;
      ALU_AND:  w_funct3 = F3_AND;
      default:  w_legal  = 1'b0;
    endcase
    w_inst = encode_rtype(rd, rs1, rs2, w_funct3, w_funct7);
  end

  // Illegal requests still complete the handshake so the producer never stalls on them.
  assign w_accept = in_valid && !w_full && !clear;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && mem_ready && !clear;

  encode_reg_inst_writer_inst_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_inst),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= BASE_ADDR;
      r_count      <= '0;
      r_illegal    <= 1'b0;
      r_last_wdata <= '0;
    end else if (clear) begin
      r_addr    <= BASE_ADDR;
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr       <= r_addr + ADDR_W'(4);
        r_last_wdata <= w_head;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
      if (w_accept && !w_legal) r_illegal <= 1'b1;
    end
  end

  assign in_ready   = !w_full;
  assign mem_we     = !w_empty;
  assign mem_addr   = r_addr;
  assign mem_wdata  = w_empty ? r_last_wdata : w_head;
  assign illegal_op = r_illegal;
  assign inst_count = r_count;
endmodule
